// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master = producer/consumer side, slave = the subtractor itself.
`timescale 1ns/1ps
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, busy
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one full-subtractor step per clock.
// Result, borrow-out and signed overflow are held until the consumer accepts them.
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic             a_sign_q;
  logic             b_sign_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic d_bit;
  logic borrow_nxt;

  always_comb begin
    d_bit      = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    borrow_nxt = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.b;
            borrow_q <= bus.bin;
            a_sign_q <= bus.a[WIDTH-1];
            b_sign_q <= bus.b[WIDTH-1];
            cnt_q    <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          res_q    <= {d_bit, res_q[WIDTH-1:1]};
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          borrow_q <= borrow_nxt;
          cnt_q    <= cnt_q + CntW'(1);
          // Publish on the last bit so diff/bout/ovf only change once per operation.
          if (cnt_q == LastCnt) begin
            diff_q  <= {d_bit, res_q[WIDTH-1:1]};
            bout_q  <= borrow_nxt;
            ovf_q   <= (a_sign_q != b_sign_q) && (d_bit != a_sign_q);
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases, back-pressure,
// mid-operation reset and a randomized back-to-back stream against an arithmetic model.
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, bout, diff} from plain integer arithmetic on the captured operands.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    int ua, ub, sa, sb, r;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    d  = W'((ua - ub - int'(bin)) & ((1 << W) - 1));
    bo = (ua < ub + int'(bin));
    r  = sa - sb - int'(bin);
    ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return {ov, bo, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands in IDLE and take one edge to have them accepted.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    check_eq("in_ready_before_start", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.bin      = 1'($urandom);
    check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input logic [W+1:0] exp);
    int cycles;
    cycles = 0;
    while (!bus.out_valid && cycles < int'(W) + 5) begin
      tick();
      cycles++;
    end
    check_eq({tag, "_latency"}, 32'(cycles), 32'(W));
    check_eq({tag, "_diff"}, 32'(bus.diff), 32'(exp[W-1:0]));
    check_eq({tag, "_bout"}, 32'(bus.bout), 32'(exp[W]));
    check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(exp[W+1]));
  endtask

  task automatic retire(input logic [W-1:0] exp_diff);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("retire_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("retire_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("retire_busy", 32'(bus.busy), 32'd0);
    check_eq("retire_diff_held", 32'(bus.diff), 32'(exp_diff));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin);
    logic [W+1:0] e;
    e = ref_sub(a, b, bin);
    start_op(a, b, bin);
    wait_done(tag, e);
    retire(e[W-1:0]);
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W+1:0] q[$];
    logic [W-1:0] ra, rb;
    logic         rbin;
    int           results, iter, last_acc;

    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    tick();
    tick();
    check_eq("rst_diff", 32'(bus.diff), 32'd0);
    check_eq("rst_bout", 32'(bus.bout), 32'd0);
    check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed corner cases.
    run_op("basic_100_37", 8'd100, 8'd37, 1'b0);
    run_op("wrap_0_1", 8'h00, 8'h01, 1'b0);
    run_op("eq_bin", 8'h05, 8'h05, 1'b1);
    run_op("ovf_neg", 8'h80, 8'h01, 1'b0);
    check_eq("ovf_neg_ref_diff", 32'(bus.diff), 32'h7F);

    // Back-pressure: result must hold while in_valid and operands wiggle.
    e = ref_sub(8'h7F, 8'hFF, 1'b0);
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_done("ovf_pos", e);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'(i);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      tick();
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_diff", 32'(bus.diff), 32'(e[W-1:0]));
      check_eq("bp_bout", 32'(bus.bout), 32'(e[W]));
      check_eq("bp_ovf", 32'(bus.ovf), 32'(e[W+1]));
    end
    bus.in_valid = 1'b0;
    retire(e[W-1:0]);
    run_op("after_bp", 8'h33, 8'h11, 1'b1);

    // Reset three cycles into RUN aborts the operation.
    start_op(8'h55, 8'h22, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mid_rst_diff", 32'(bus.diff), 32'd0);
    check_eq("mid_rst_bout", 32'(bus.bout), 32'd0);
    check_eq("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    run_op("post_rst", 8'h10, 8'h01, 1'b0);

    // Back-to-back random stream with both handshakes held high.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    results       = 0;
    iter          = 0;
    last_acc      = -1;
    while (results < 20 && iter < 20 * (int'(W) + 2) + 50) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check_eq("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check_eq("b2b_diff", 32'(bus.diff), 32'(e[W-1:0]));
          check_eq("b2b_bout", 32'(bus.bout), 32'(e[W]));
          check_eq("b2b_ovf", 32'(bus.ovf), 32'(e[W+1]));
        end
        results++;
      end
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      bus.a   = ra;
      bus.b   = rb;
      bus.bin = rbin;
      if (bus.in_ready) begin
        q.push_back(ref_sub(ra, rb, rbin));
        if (last_acc >= 0) begin
          check_eq("b2b_interval", 32'(iter - last_acc), 32'(W + 2));
        end
        last_acc = iter;
      end
      tick();
      iter++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("b2b_result_count", 32'(results), 32'd20);
    check_eq("b2b_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
